fp_mul_arbiter: RTL and testbench

// Shares one FP_mul_top single-precision multiplier between NUM_REQ requesters.

---
 rtl/fp_mul_arbiter.sv | 168 ++++++++++++++++
 tb/tb_fp_mul_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arbiter.sv
// fp_mul_arbiter
//   Shares one single-precision multiplier core between NUM_REQ requesters.
//   Requests are granted round-robin. For each grant the block registers the
//   operands, pulses fp_start_o, waits for fp_done_i (or times out) and parks
//   the product in the requester's response slot until it is consumed.
//
// Ports
//   clk_i, rst_i          clock (rising edge), synchronous active-high reset
//   req_valid_i/_ready_o  per-requester operand handshake (ready is one-hot)
//   req_a_i, req_b_i      operands, requester i at [32*i +: 32]
//   rsp_valid_o/_data_o   per-requester result slot, held until rsp_ready_i
//   rsp_ready_i           requester i consumes its result
//   fp_start_o            one-cycle start pulse to the multiplier core
//   fp_a_o, fp_b_o        operands to the core, held between operations
//   fp_result_i/_done_i   core product and completion
//   busy_o                high whenever not IDLE
//   timeout_err_o         sticky timeout flag, cleared only by reset
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | look for an eligible requester, accept it, latch operands
// S_START | pulse fp_start_o, clear the timeout counter
// S_WAIT  | wait for fp_done_i; deliver product or qNaN on timeout
module fp_mul_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ*32-1:0]  req_a_i,
  input  logic [NUM_REQ*32-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [NUM_REQ*32-1:0]  rsp_data_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic                   fp_start_o,
  output logic [31:0]            fp_a_o,
  output logic [31:0]            fp_b_o,
  input  logic [31:0]            fp_result_i,
  input  logic                   fp_done_i,
  output logic                   busy_o,
  output logic                   timeout_err_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [PW-1:0]         ptr_q, ptr_d;
  logic [PW-1:0]         gnt_q, gnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           fp_a_q, fp_a_d;
  logic [31:0]           fp_b_q, fp_b_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ*32-1:0] rsp_data_q, rsp_data_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_REQ-1:0]    req_ready;

  logic [NUM_REQ-1:0]    elig;
  logic [PW-1:0]         pick;
  logic [PW-1:0]         idx;
  logic                  found;

  // A requester with an unconsumed result is skipped so its slot never
  // receives a second product before the first is read.
  assign elig = req_valid_i & ~rsp_valid_q;

  // Round-robin search starting at ptr+1. Scanning from the far end means
  // the last hit written is the nearest one after the pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = PW'((int'(ptr_q) + k) % NUM_REQ);
      if (elig[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    fp_a_d      = fp_a_q;
    fp_b_d      = fp_b_q;
    rsp_valid_d = rsp_valid_q & ~rsp_ready_i;
    rsp_data_d  = rsp_data_q;
    timeout_d   = timeout_q;
    req_ready   = '0;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready[pick] = 1'b1;
          fp_a_d          = req_a_i[int'(pick)*32 +: 32];
          fp_b_d          = req_b_i[int'(pick)*32 +: 32];
          gnt_d           = pick;
          state_d         = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fp_done_i) begin
          rsp_data_d[int'(gnt_q)*32 +: 32] = fp_result_i;
          rsp_valid_d[gnt_q]               = 1'b1;
          ptr_d                            = gnt_q;
          state_d                          = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          rsp_data_d[int'(gnt_q)*32 +: 32] = QNAN;
          rsp_valid_d[gnt_q]               = 1'b1;
          timeout_d                        = 1'b1;
          ptr_d                            = gnt_q;
          state_d                          = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(NUM_REQ - 1);
      gnt_q       <= '0;
      cnt_q       <= '0;
      fp_a_q      <= '0;
      fp_b_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      cnt_q       <= cnt_d;
      fp_a_q      <= fp_a_d;
      fp_b_q      <= fp_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      timeout_q   <= timeout_d;
    end
  end

  assign req_ready_o   = req_ready;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign fp_start_o    = (state_q == S_START);
  assign fp_a_o        = fp_a_q;
  assign fp_b_o        = fp_b_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = timeout_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
module tb_fp_mul_arbiter;
  localparam int NR = 4;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR-1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*32-1:0] req_a, req_b, rsp_data;
  logic           fp_start, fp_done, busy, timeout_err;
  logic [31:0]    fp_a, fp_b, fp_result;

  // multiplier stub
  logic        stub_done, man_done, core_en, core_busy;
  logic [31:0] stub_result, man_result;
  int          core_cnt, done_lat;

  int vectors = 0;
  int miscompares = 0;
  int gq[$];
  int bad_oh = 0;
  int n, starts;

  assign fp_done   = stub_done | man_done;
  assign fp_result = man_done ? man_result : stub_result;

  always #5 clk = ~clk;

  fp_mul_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_ready_i(rsp_ready),
    .fp_start_o(fp_start), .fp_a_o(fp_a), .fp_b_o(fp_b),
    .fp_result_i(fp_result), .fp_done_i(fp_done),
    .busy_o(busy), .timeout_err_o(timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst = 1'b1; req_valid = '0; rsp_ready = '0; man_done = 1'b0;
    tick; tick;
    rst = 1'b0;
    gq.delete();
  endtask

  task automatic wait_grants(input int cnt, input string tag);
    for (int c = 0; c < 400 && gq.size() < cnt; c++) tick;
    chk(tag, 32'(gq.size()), 32'(cnt));
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200 && busy; c++) tick;
    chk(tag, 32'(busy), 32'd0);
  endtask

  // Multiplier stub: done pulses done_lat cycles after the start pulse.
  initial begin
    stub_done = 1'b0; stub_result = '0; core_busy = 1'b0; core_cnt = 0;
    forever begin
      @(posedge clk); #1;
      stub_done = 1'b0;
      if (rst) core_busy = 1'b0;
      else begin
        if (core_busy) begin
          core_cnt--;
          if (core_cnt == 0) begin
            stub_done   = 1'b1;
            stub_result = (fp_a == 32'h4040_0000 && fp_b == 32'h4000_0000) ?
                          32'h40C0_0000 : (fp_a ^ fp_b);
            core_busy   = 1'b0;
          end
        end
        if (fp_start && core_en) begin
          core_busy = 1'b1;
          core_cnt  = done_lat;
        end
      end
    end
  end

  // Grant monitor: records which requester sees req_ready in each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && req_ready != '0) begin
        if (!$onehot(req_ready)) bad_oh++;
        for (int i = NR - 1; i >= 0; i--) if (req_ready[i]) n = i;
        gq.push_back(n);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
    man_done = 1'b0; man_result = 32'hDEAD_BEEF; core_en = 1'b1; done_lat = 5;
    tick; tick;
    // reset values
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_fp_start", 32'(fp_start), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    chk("rst_fp_a", fp_a, 32'd0);
    chk("rst_fp_b", fp_b, 32'd0);
    chk("rst_rsp_data", rsp_data[31:0] | rsp_data[63:32] | rsp_data[95:64] | rsp_data[127:96], 32'd0);

    // 1) single multiply, core done 5 cycles after start
    rst = 1'b0; gq.delete();
    req_valid = 4'b0001; req_a[31:0] = 32'h4040_0000; req_b[31:0] = 32'h4000_0000;
    @(negedge clk);
    chk("t1_req_ready", 32'(req_ready), 32'h1);
    tick;
    req_valid = '0;
    chk("t1_fp_start", 32'(fp_start), 32'd1);
    chk("t1_fp_a", fp_a, 32'h4040_0000);
    chk("t1_fp_b", fp_b, 32'h4000_0000);
    chk("t1_busy", 32'(busy), 32'd1);
    n = 0; starts = 0;
    for (int c = 0; c < 40; c++) begin
      tick; n++;
      if (fp_start) starts++;
      if (rsp_valid[0]) break;
    end
    chk("t1_latency", 32'(n), 32'd6);
    chk("t1_start_once", 32'(starts), 32'd0);
    chk("t1_rsp_data", rsp_data[31:0], 32'h40C0_0000);
    tick;
    chk("t1_rsp_hold", 32'(rsp_valid), 32'h1);
    rsp_ready = 4'b0001;
    tick;
    rsp_ready = '0;
    chk("t1_rsp_clear", 32'(rsp_valid), 32'h0);
    chk("t1_idle", 32'(busy), 32'd0);

    // 2) all requesters valid: rotation 0,1,2,3,0
    do_reset;
    done_lat = 2; bad_oh = 0;
    for (int i = 0; i < NR; i++) begin
      req_a[32*i +: 32] = 32'h3F80_0000 + 32'(i);
      req_b[32*i +: 32] = 32'h1000_0000 * 32'(i);
    end
    rsp_ready = 4'b1111; req_valid = 4'b1111;
    wait_grants(5, "t2_grant_count");
    req_valid = '0;
    wait_idle("t2_idle");
    chk("t2_g0", 32'(gq[0]), 32'd0);
    chk("t2_g1", 32'(gq[1]), 32'd1);
    chk("t2_g2", 32'(gq[2]), 32'd2);
    chk("t2_g3", 32'(gq[3]), 32'd3);
    chk("t2_g4", 32'(gq[4]), 32'd0);
    chk("t2_onehot", 32'(bad_oh), 32'd0);
    chk("t2_data0", rsp_data[31:0],   32'h3F80_0000);
    chk("t2_data1", rsp_data[63:32],  32'h2F80_0001);
    chk("t2_data2", rsp_data[95:64],  32'h1F80_0002);
    chk("t2_data3", rsp_data[127:96], 32'h0F80_0003);

    // 3) requester 1 response not consumed: it must be skipped
    do_reset;
    rsp_ready = 4'b1101; req_valid = 4'b1111;
    wait_grants(8, "t3_grant_count");
    chk("t3_rsp1_held", 32'(rsp_valid[1]), 32'd1);
    chk("t3_g0", 32'(gq[0]), 32'd0);
    chk("t3_g1", 32'(gq[1]), 32'd1);
    chk("t3_g2", 32'(gq[2]), 32'd2);
    chk("t3_g3", 32'(gq[3]), 32'd3);
    chk("t3_g4", 32'(gq[4]), 32'd0);
    chk("t3_g5", 32'(gq[5]), 32'd2);
    chk("t3_g6", 32'(gq[6]), 32'd3);
    chk("t3_g7", 32'(gq[7]), 32'd0);
    rsp_ready = 4'b1111;
    wait_grants(9, "t3_regrant_count");
    req_valid = '0;
    chk("t3_g8", 32'(gq[8]), 32'd1);
    wait_idle("t3_idle");
    chk("t3_onehot", 32'(bad_oh), 32'd0);

    // 4) core never completes: qNaN after timeout, sticky error
    do_reset;
    core_en = 1'b0;
    req_valid = 4'b0100;
    req_a[95:64] = 32'h4110_0000; req_b[95:64] = 32'h4120_0000;
    @(negedge clk);
    chk("t4_req_ready", 32'(req_ready), 32'h4);
    tick;
    req_valid = '0;
    chk("t4_fp_start", 32'(fp_start), 32'd1);
    n = 0;
    for (int c = 0; c < 120; c++) begin
      tick; n++;
      if (rsp_valid[2]) break;
      if (n == 64) chk("t4_no_early_err", 32'(timeout_err), 32'd0);
    end
    chk("t4_latency", 32'(n), 32'd65);
    chk("t4_qnan", rsp_data[95:64], 32'h7FC0_0000);
    chk("t4_timeout_err", 32'(timeout_err), 32'd1);
    chk("t4_idle", 32'(busy), 32'd0);
    core_en = 1'b1; done_lat = 3;
    req_valid = 4'b0001;
    req_a[31:0] = 32'h1234_5678; req_b[31:0] = 32'h0F0F_0F0F;
    tick;
    req_valid = '0;
    for (int c = 0; c < 40 && !rsp_valid[0]; c++) tick;
    chk("t4_next_data", rsp_data[31:0], 32'h1D3B_5977);
    chk("t4_sticky", 32'(timeout_err), 32'd1);
    chk("t4_slot2_held", 32'(rsp_valid[2]), 32'd1);

    // 5) reset two cycles into WAIT, then a late done
    core_en = 1'b0;
    req_valid = 4'b1000;
    req_a[127:96] = 32'h3F00_0000; req_b[127:96] = 32'h3F00_0000;
    @(negedge clk);
    chk("t5_req_ready", 32'(req_ready), 32'h8);
    tick;
    req_valid = '0;
    tick; tick;
    chk("t5_in_wait", 32'(busy), 32'd1);
    rst = 1'b1;
    tick;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t5_fp_start", 32'(fp_start), 32'd0);
    chk("t5_timeout", 32'(timeout_err), 32'd0);
    chk("t5_fp_a", fp_a, 32'd0);
    rst = 1'b0; man_done = 1'b1;
    tick;
    man_done = 1'b0;
    tick;
    chk("t5_late_done_rsp", 32'(rsp_valid), 32'd0);
    chk("t5_late_done_busy", 32'(busy), 32'd0);

    // 6) done pulse while IDLE with a pending response
    core_en = 1'b1; done_lat = 1;
    req_valid = 4'b0010;
    req_a[63:32] = 32'hAAAA_0000; req_b[63:32] = 32'h0000_5555;
    tick;
    req_valid = '0;
    for (int c = 0; c < 20 && !rsp_valid[1]; c++) tick;
    chk("t6_data", rsp_data[63:32], 32'hAAAA_5555);
    man_done = 1'b1;
    tick;
    man_done = 1'b0;
    chk("t6_busy", 32'(busy), 32'd0);
    tick;
    chk("t6_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("t6_data_kept", rsp_data[63:32], 32'hAAAA_5555);
    chk("t6_busy2", 32'(busy), 32'd0);
    chk("t6_fp_start", 32'(fp_start), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
